// File: rtl/fib_request_scheduler.sv
// Two-requester front end for a recursive Fibonacci engine.
// Round-robin arbitration, one job in flight, watchdog abort on a stuck engine.
module fib_request_scheduler #(
    parameter int NW      = 4,
    parameter int RW      = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [NW-1:0] n0,
    input  logic [NW-1:0] n1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic          err,
    output logic [RW-1:0] result,
    output logic          eng_start,
    output logic [NW-1:0] eng_n,
    output logic          eng_abort,
    input  logic          eng_done,
    input  logic [RW-1:0] eng_result
);

    localparam int            CW    = $clog2(TIMEOUT + 1);
    // Last WAIT cycle before the watchdog fires (counter starts at 0 in WAIT).
    localparam logic [CW-1:0] TO_M1 = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, DELIVER} state_t;

    state_t          state_q;
    logic            owner_q;
    logic            last_q;
    logic [CW-1:0]   cnt_q;
    logic [NW-1:0]   eng_n_q;
    logic [RW-1:0]   result_q;
    logic            err_q;
    logic            gnt0_q, gnt1_q, done0_q, done1_q;
    logic            eng_start_q, eng_abort_q;
    logic            win_d;

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        win_d = req1;
        if (req0 && req1) win_d = ~last_q;
    end

    // Job FSM; every output is registered and pulses are cleared by default.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            eng_n_q     <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            eng_start_q <= 1'b0;
            eng_abort_q <= 1'b0;
        end else begin
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            eng_start_q <= 1'b0;
            eng_abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        owner_q     <= win_d;
                        eng_n_q     <= win_d ? n1 : n0;
                        gnt0_q      <= ~win_d;
                        gnt1_q      <= win_d;
                        eng_start_q <= 1'b1;
                        state_q     <= START;
                    end
                end
                START: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    // A completion in the watchdog's last cycle still counts.
                    if (eng_done) begin
                        result_q <= eng_result;
                        err_q    <= 1'b0;
                        done0_q  <= ~owner_q;
                        done1_q  <= owner_q;
                        state_q  <= DELIVER;
                    end else if (cnt_q == TO_M1) begin
                        eng_abort_q <= 1'b1;
                        result_q    <= '0;
                        err_q       <= 1'b1;
                        done0_q     <= ~owner_q;
                        done1_q     <= owner_q;
                        state_q     <= DELIVER;
                    end
                end
                DELIVER: begin
                    last_q  <= owner_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign err       = err_q;
    assign result    = result_q;
    assign eng_start = eng_start_q;
    assign eng_n     = eng_n_q;
    assign eng_abort = eng_abort_q;

endmodule
